if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Parametrised fetch->decode boundary for the 5-stage pipeline: a depth-configurable
//  instruction queue with a valid/ready handshake on both sides and a synchronous flush.
//  Decouples fetch from decode stalls. On a redirect, a flush removes all in-flight
//  instructions, and decode then sees a NOP bubble.
// PARAMETERS
//  word_width  32            width of instr, PC and PC+4 fields
//  depth       2             number of queue entries (>=1, any integer, not restricted to 2^n)
//  nop_instr   32'h00000013  instruction presented on instrD when queue empty (addi x0,x0,0)
// PORTS
//  clk       in   1           rising-edge clock
//  reset     in   1           synchronous, active-high reset
//  validF    in   1           fetch presents an instruction this cycle
//  readyF    out  1           queue can accept (count < depth)
//  instrF    in   word_width  fetched instruction
//  PCF       in   word_width  PC of instrF
//  PCPlus4F  in   word_width  PC+4 of instrF
//  enableD   in   1           decode consumes head this cycle (active-low stall)
//  flushD    in   1           synchronous flush (branch/jump redirect)
//  validD    out  1           head entry valid (count != 0)
//  instrD    out  word_width  head instruction, or nop_instr when empty
//  PCD       out  word_width  head PC, 0 when empty
//  PCPlus4D  out  word_width  head PC+4, 0 when empty
//  countD    out  $clog2(depth+1)  occupancy, 0..depth
// BEHAVIOUR
//  - Storage: depth entries of {instr, PC, PCPlus4}; rd_ptr, wr_ptr in 0..depth-1; count 0..depth.
//  - push = validF & readyF; pop = validD & enableD. readyF = (count < depth), from registered
//    count only, with no combinational path from enableD.
//  - Pointers wrap explicitly: ptr == depth-1 -> 0 on advance, so non-power-of-2 depth works.
//  - Count update: push&!pop +1; pop&!push -1; push&pop unchanged (legal when 0<count<depth).
//  - When full, push is blocked even if pop is asserted in the same cycle, so readyF=0 when count=depth.
//  - Outputs are combinational from the head entry and registered count. When count=0: validD=0,
//    instrD=nop_instr, PCD=0, PCPlus4D=0.
//  - Latency: an entry pushed at edge N is visible on the D outputs after edge N. There is no
//    fall-through while empty.
//  - Ordering: strict FIFO; entries are never reordered or duplicated.
//  - flushD: on the next edge count=0 and rd_ptr=wr_ptr=0. Flush has priority over push and pop.
//    A push or pop in the flush cycle is discarded and the popped head is not consumed.
//    readyF is unaffected in the flush cycle.
//  - reset: same state effect as flushD. It has priority over flushD. Storage contents are
//    don't-care, and outputs after the edge are validD=0, instrD=nop_instr, PCD=0,
//    PCPlus4D=0, countD=0, readyF=1.
//  - Reset or flush mid-stream: no entry present before the edge may appear on the D outputs
//    afterwards.
//  - enableD=0 holds all outputs stable; pushes continue until full.
//  - Depth=1 degenerates to the classic IF/ID register with a valid bit. In that case readyF is
//    low while the entry is held, including in a pop cycle.
// TESTING
//  1. Reset: assert reset 1 cycle -> validD=0, instrD=0x13, PCD=0, countD=0, readyF=1.
//  2. Stream: depth=2, enableD=1, push instr 0xA,0xB,0xC on PC 0x0,0x4,0x8 back-to-back ->
//     same order on instrD/PCD, each 1 cycle after push, with no loss.
//  3. Stall/full: enableD=0, push 0xA,0xB,0xC -> countD=2, readyF=0, 0xC held in fetch, instrD=0xA.
//     Then enableD=1 -> 0xA,0xB,0xC drain in order.
//  4. Flush: countD=2 with validF=1 and enableD=1, assert flushD -> next cycle countD=0,
//    validD=0, instrD=0x13. The new push is dropped and the next push appears first.
//  5. Wrap: depth=3, push/pop 10 entries with random stalls -> order preserved and pointers wrap
//     past index 2.
//  6. Simultaneous: count=1, push 0xD and pop the same cycle -> countD stays 1, instrD=0xD next cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch->decode instruction queue with valid/ready on both sides.
// Flush and reset empty the queue; an empty queue presents a NOP bubble.
module if_id_queue #(
  parameter int unsigned          word_width = 32,
  parameter int unsigned          depth      = 2,
  parameter logic [word_width-1:0] nop_instr = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         validF,
  output logic                         readyF,
  input  logic [word_width-1:0]        instrF,
  input  logic [word_width-1:0]        PCF,
  input  logic [word_width-1:0]        PCPlus4F,
  input  logic                         enableD,
  input  logic                         flushD,
  output logic                         validD,
  output logic [word_width-1:0]        instrD,
  output logic [word_width-1:0]        PCD,
  output logic [word_width-1:0]        PCPlus4D,
  output logic [$clog2(depth+1)-1:0]   countD
);

  localparam int unsigned CW = $clog2(depth + 1);
  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [CW-1:0] FULL = CW'(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  logic [word_width-1:0] instr_q [depth];
  logic [word_width-1:0] pc_q    [depth];
  logic [word_width-1:0] pc4_q   [depth];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push, pop;

  assign readyF = (cnt_q < FULL);
  assign validD = (cnt_q != '0);
  assign push   = validF & readyF;
  assign pop    = validD & enableD;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (reset || flushD) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push && !reset && !flushD) begin
      instr_q[wr_q] <= instrF;
      pc_q[wr_q]    <= PCF;
      pc4_q[wr_q]   <= PCPlus4F;
    end
  end

  assign instrD   = validD ? instr_q[rd_q] : nop_instr;
  assign PCD      = validD ? pc_q[rd_q]    : '0;
  assign PCPlus4D = validD ? pc4_q[rd_q]   : '0;
  assign countD   = cnt_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: depth-2 scenarios and a depth-3 wrap run.
// Expected values are hand-derived or come from a small queue model.
module tb_if_id_queue;

  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;

  logic        a_validF = 0, a_enableD = 0, a_flushD = 0;
  logic [31:0] a_instrF = 0, a_PCF = 0, a_PC4F = 0;
  logic        a_readyF, a_validD;
  logic [31:0] a_instrD, a_PCD, a_PC4D;
  logic [1:0]  a_countD;

  logic        b_validF = 0, b_enableD = 0, b_flushD = 0;
  logic [31:0] b_instrF = 0, b_PCF = 0, b_PC4F = 0;
  logic        b_readyF, b_validD;
  logic [31:0] b_instrD, b_PCD, b_PC4D;
  logic [1:0]  b_countD;

  if_id_queue #(.word_width(32), .depth(2)) dut_a (
    .clk(clk), .reset(reset),
    .validF(a_validF), .readyF(a_readyF),
    .instrF(a_instrF), .PCF(a_PCF), .PCPlus4F(a_PC4F),
    .enableD(a_enableD), .flushD(a_flushD),
    .validD(a_validD), .instrD(a_instrD),
    .PCD(a_PCD), .PCPlus4D(a_PC4D), .countD(a_countD)
  );

  if_id_queue #(.word_width(32), .depth(3)) dut_b (
    .clk(clk), .reset(reset),
    .validF(b_validF), .readyF(b_readyF),
    .instrF(b_instrF), .PCF(b_PCF), .PCPlus4F(b_PC4F),
    .enableD(b_enableD), .flushD(b_flushD),
    .validD(b_validD), .instrD(b_instrD),
    .PCD(b_PCD), .PCPlus4D(b_PC4D), .countD(b_countD)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fa(input logic v, input logic [31:0] i,
                    input logic [31:0] pc);
    a_validF = v;
    a_instrF = i;
    a_PCF    = pc;
    a_PC4F   = pc + 32'd4;
  endtask

  task automatic ca(input string tag, input logic v,
                    input logic [31:0] i, input logic [31:0] pc,
                    input logic [1:0] c, input logic r);
    chk({tag, ".validD"}, {31'd0, a_validD}, {31'd0, v});
    chk({tag, ".instrD"}, a_instrD, i);
    chk({tag, ".PCD"}, a_PCD, pc);
    chk({tag, ".PCPlus4D"}, a_PC4D, v ? pc + 32'd4 : 32'd0);
    chk({tag, ".countD"}, {30'd0, a_countD}, {30'd0, c});
    chk({tag, ".readyF"}, {31'd0, a_readyF}, {31'd0, r});
  endtask

  logic [31:0] q[$];
  int pushed, popped;
  logic pu, po;

  initial begin
    // 1. reset
    reset = 1;
    step;
    reset = 0;
    ca("reset", 0, 32'h13, 0, 0, 1);
    chk("reset.b.count", {30'd0, b_countD}, 0);
    chk("reset.b.instrD", b_instrD, 32'h13);

    // 2. stream
    a_enableD = 1;
    fa(1, 32'hA, 32'h0); step;
    ca("stream.A", 1, 32'hA, 32'h0, 1, 1);
    fa(1, 32'hB, 32'h4); step;
    ca("stream.B", 1, 32'hB, 32'h4, 1, 1);
    fa(1, 32'hC, 32'h8); step;
    ca("stream.C", 1, 32'hC, 32'h8, 1, 1);
    fa(0, 0, 0); step;
    ca("stream.empty", 0, 32'h13, 0, 0, 1);

    // 3. stall / full
    a_enableD = 0;
    fa(1, 32'hA, 32'h0); step;
    ca("stall.1", 1, 32'hA, 32'h0, 1, 1);
    fa(1, 32'hB, 32'h4); step;
    ca("stall.full", 1, 32'hA, 32'h0, 2, 0);
    fa(1, 32'hC, 32'h8); step;
    ca("stall.held", 1, 32'hA, 32'h0, 2, 0);
    a_enableD = 1; step;
    ca("drain.B", 1, 32'hB, 32'h4, 1, 1);
    step;
    ca("drain.C", 1, 32'hC, 32'h8, 1, 1);
    fa(0, 0, 0); step;
    ca("drain.empty", 0, 32'h13, 0, 0, 1);

    // 4. flush
    a_enableD = 0;
    fa(1, 32'hE, 32'h20); step;
    fa(1, 32'hF, 32'h24); step;
    ca("flush.pre", 1, 32'hE, 32'h20, 2, 0);
    fa(1, 32'h11, 32'h28);
    a_enableD = 1;
    a_flushD = 1; step;
    a_flushD = 0;
    ca("flush.post", 0, 32'h13, 0, 0, 1);
    a_enableD = 0;
    fa(1, 32'h22, 32'h40); step;
    ca("flush.next", 1, 32'h22, 32'h40, 1, 1);

    // 6. simultaneous push/pop at count 1
    a_enableD = 1;
    fa(1, 32'hD, 32'h44); step;
    ca("simul", 1, 32'hD, 32'h44, 1, 1);

    // mid-stream reset beats flush and push
    a_enableD = 0;
    fa(1, 32'h33, 32'h48);
    a_flushD = 1;
    reset = 1; step;
    reset = 0;
    a_flushD = 0;
    fa(0, 0, 0);
    ca("reset.mid", 0, 32'h13, 0, 0, 1);

    // 5. depth-3 wrap with random stalls, checked against a queue model
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
      b_validF  = (pushed < 10) && ($urandom_range(0, 3) != 0);
      b_enableD = ($urandom_range(0, 2) != 0);
      b_instrF  = 32'h100 + pushed;
      b_PCF     = 32'h1000 + 4 * pushed;
      b_PC4F    = b_PCF + 32'd4;
      pu = b_validF && (q.size() < 3);
      po = b_enableD && (q.size() != 0);
      step;
      if (po) begin
        void'(q.pop_front());
        popped++;
      end
      if (pu) begin
        q.push_back(b_instrF);
        pushed++;
      end
      chk("wrap.count", {30'd0, b_countD}, q.size());
      chk("wrap.instrD", b_instrD, q.size() != 0 ? q[0] : 32'h13);
      chk("wrap.PCD", b_PCD,
          q.size() != 0 ? 32'h1000 + 4 * (q[0] - 32'h100) : 32'd0);
    end
    chk("wrap.all_popped", popped, 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
